// File: rtl/point_cloud_loader.sv
// Streams a point cloud into x/y/z BRAMs, hands it to an accelerator through a
// header word handshake, then streams the filtered points back out.
module point_cloud_loader #(
    parameter int N          = 16,
    parameter int BUS_SIZE   = 32,
    parameter int BRAM_SHIFT = 2,
    parameter int MAX_POINTS = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        in_x,
    input  logic [N-1:0]        in_y,
    input  logic [N-1:0]        in_z,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_x,
    output logic [N-1:0]        out_y,
    output logic [N-1:0]        out_z,
    output logic                out_outlier,
    output logic                out_last,
    output logic [31:0]         addr_x,
    output logic [31:0]         addr_y,
    output logic [31:0]         addr_z,
    output logic [BUS_SIZE-1:0] write_in_x,
    output logic [BUS_SIZE-1:0] write_in_y,
    output logic [BUS_SIZE-1:0] write_in_z,
    input  logic [BUS_SIZE-1:0] read_out_x,
    input  logic [BUS_SIZE-1:0] read_out_y,
    input  logic [BUS_SIZE-1:0] read_out_z,
    output logic                en_x,
    output logic                en_y,
    output logic                en_z,
    output logic [3:0]          we_x,
    output logic [3:0]          we_y,
    output logic [3:0]          we_z,
    output logic                busy,
    output logic                overflow
);

    localparam int CW = $clog2(MAX_POINTS + 1);
    localparam logic [BUS_SIZE-1:0] DONE_MAGIC = BUS_SIZE'(32'h0000_0FFF);

    typedef enum logic [3:0] {
        IDLE, LOAD, FLUSH, HEADER, START, WAIT_ADDR, WAIT_CHK,
        RD_ADDR, RD_WAIT, EMIT_LO, EMIT_HI, FINISH
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_p;
    logic            r_overflow;
    logic [N-1:0]    r_pack_x, r_pack_y, r_pack_z;
    logic [2*N-1:0]  r_unload_x, r_unload_y, r_unload_z;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_drop;
    logic            w_last_pt;
    logic            w_emit;
    logic [CW-1:0]   w_count_next;
    logic [31:0]     w_ld_addr;
    logic [31:0]     w_rd_addr;

    assign w_in_ready   = !reset && (r_state == IDLE || r_state == LOAD);
    assign w_accept     = in_valid && w_in_ready;
    assign w_drop       = (r_state == LOAD) && (r_count == CW'(MAX_POINTS));
    assign w_count_next = w_drop ? r_count : r_count + CW'(1);
    assign w_last_pt    = (r_p == r_count - CW'(1));
    assign w_emit       = (r_state == EMIT_LO) || (r_state == EMIT_HI);
    // Word holding point index r_count (load side) or r_p (unload side); word 0 is the header.
    assign w_ld_addr    = ((32'(r_count) >> 1) + 32'd1) << BRAM_SHIFT;
    assign w_rd_addr    = ((32'(r_p) >> 1) + 32'd1) << BRAM_SHIFT;

    assign in_ready    = w_in_ready;
    assign busy        = !reset && (r_state != IDLE);
    assign overflow    = r_overflow;
    assign out_valid   = !reset && w_emit;
    assign out_last    = out_valid && w_last_pt;
    assign out_x       = (r_state == EMIT_HI) ? r_unload_x[2*N-1:N] : r_unload_x[N-1:0];
    assign out_y       = (r_state == EMIT_HI) ? r_unload_y[2*N-1:N] : r_unload_y[N-1:0];
    assign out_z       = (r_state == EMIT_HI) ? r_unload_z[2*N-1:N] : r_unload_z[N-1:0];
    assign out_outlier = (out_x == '0) && (out_y == '0) && (out_z == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_p        <= '0;
            r_overflow <= 1'b0;
            r_pack_x   <= '0;
            r_pack_y   <= '0;
            r_pack_z   <= '0;
            r_unload_x <= '0;
            r_unload_y <= '0;
            r_unload_z <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_count  <= CW'(1);
                        r_p      <= '0;
                        r_pack_x <= in_x;
                        r_pack_y <= in_y;
                        r_pack_z <= in_z;
                        r_state  <= in_last ? FLUSH : LOAD;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        if (w_drop) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count <= r_count + CW'(1);
                            if (!r_count[0]) begin
                                r_pack_x <= in_x;
                                r_pack_y <= in_y;
                                r_pack_z <= in_z;
                            end
                        end
                        if (in_last) begin
                            r_state <= w_count_next[0] ? FLUSH : HEADER;
                        end
                    end
                end
                FLUSH:     r_state <= HEADER;
                HEADER: begin
                    r_p     <= '0;
                    r_state <= START;
                end
                START:     r_state <= WAIT_ADDR;
                WAIT_ADDR: r_state <= WAIT_CHK;
                WAIT_CHK:  r_state <= (read_out_z == DONE_MAGIC) ? RD_ADDR : WAIT_ADDR;
                RD_ADDR:   r_state <= RD_WAIT;
                RD_WAIT: begin
                    r_unload_x <= read_out_x[2*N-1:0];
                    r_unload_y <= read_out_y[2*N-1:0];
                    r_unload_z <= read_out_z[2*N-1:0];
                    r_state    <= EMIT_LO;
                end
                EMIT_LO: begin
                    if (out_ready) begin
                        if (w_last_pt) begin
                            r_state <= FINISH;
                        end else begin
                            r_p     <= r_p + CW'(1);
                            r_state <= EMIT_HI;
                        end
                    end
                end
                EMIT_HI: begin
                    if (out_ready) begin
                        if (w_last_pt) begin
                            r_state <= FINISH;
                        end else begin
                            r_p     <= r_p + CW'(1);
                            r_state <= RD_ADDR;
                        end
                    end
                end
                FINISH:    r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    // BRAM port decode; everything is quiet while reset is held so an abort never writes.
    always_comb begin
        en_x = 1'b0;  en_y = 1'b0;  en_z = 1'b0;
        we_x = 4'h0;  we_y = 4'h0;  we_z = 4'h0;
        addr_x = '0;  addr_y = '0;  addr_z = '0;
        write_in_x = '0;  write_in_y = '0;  write_in_z = '0;
        if (!reset && r_state != IDLE) begin
            en_x = 1'b1;  en_y = 1'b1;  en_z = 1'b1;
            case (r_state)
                LOAD: begin
                    if (w_accept && !w_drop && r_count[0]) begin
                        addr_x = w_ld_addr;  addr_y = w_ld_addr;  addr_z = w_ld_addr;
                        write_in_x = BUS_SIZE'({in_x, r_pack_x});
                        write_in_y = BUS_SIZE'({in_y, r_pack_y});
                        write_in_z = BUS_SIZE'({in_z, r_pack_z});
                        we_x = 4'hF;  we_y = 4'hF;  we_z = 4'hF;
                    end
                end
                FLUSH: begin
                    addr_x = w_ld_addr;  addr_y = w_ld_addr;  addr_z = w_ld_addr;
                    write_in_x = BUS_SIZE'(r_pack_x);
                    write_in_y = BUS_SIZE'(r_pack_y);
                    write_in_z = BUS_SIZE'(r_pack_z);
                    we_x = 4'hF;  we_y = 4'hF;  we_z = 4'hF;
                end
                HEADER: begin
                    write_in_x = BUS_SIZE'(r_count);
                    we_x = 4'hF;
                    we_z = 4'hF;
                end
                START: begin
                    write_in_y = BUS_SIZE'(1);
                    we_y = 4'hF;
                end
                RD_ADDR, RD_WAIT, EMIT_LO, EMIT_HI: begin
                    addr_x = w_rd_addr;  addr_y = w_rd_addr;  addr_z = w_rd_addr;
                end
                FINISH: begin
                    we_z = 4'hF;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_point_cloud_loader.sv
// Bench for point_cloud_loader: BRAM + accelerator model, random clouds, and a
// per-cycle output comparator against expectations computed from the point list.
module tb_point_cloud_loader;

    localparam int N     = 16;
    localparam int BS    = 32;
    localparam int SH    = 2;
    localparam int MAXP  = 8;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0, in_last = 1'b0;
    logic [N-1:0]  in_x = '0, in_y = '0, in_z = '0;
    logic          in_ready;
    logic          out_valid, out_outlier, out_last;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_x, out_y, out_z;
    logic [31:0]   addr_x, addr_y, addr_z;
    logic [BS-1:0] write_in_x, write_in_y, write_in_z;
    logic [BS-1:0] read_out_x = '0, read_out_y = '0, read_out_z = '0;
    logic          en_x, en_y, en_z;
    logic [3:0]    we_x, we_y, we_z;
    logic          busy, overflow;

    point_cloud_loader #(.N(N), .BUS_SIZE(BS), .BRAM_SHIFT(SH), .MAX_POINTS(MAXP)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .out_outlier(out_outlier), .out_last(out_last),
        .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z),
        .write_in_x(write_in_x), .write_in_y(write_in_y), .write_in_z(write_in_z),
        .read_out_x(read_out_x), .read_out_y(read_out_y), .read_out_z(read_out_z),
        .en_x(en_x), .en_y(en_y), .en_z(en_z),
        .we_x(we_x), .we_y(we_y), .we_z(we_z),
        .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // BRAM and accelerator model
    logic [BS-1:0] mem_x [0:DEPTH-1] = '{default: '0};
    logic [BS-1:0] mem_y [0:DEPTH-1] = '{default: '0};
    logic [BS-1:0] mem_z [0:DEPTH-1] = '{default: '0};
    int            acc_cmd  = 0;
    int            acc_done = 0;
    logic [15:0]   acc_zmask = '0;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> SH) % DEPTH);
    endfunction

    always @(posedge clock) begin
        if (en_x) begin
            read_out_x <= mem_x[widx(addr_x)];
            for (int b = 0; b < 4; b++) if (we_x[b]) mem_x[widx(addr_x)][8*b +: 8] <= write_in_x[8*b +: 8];
        end
        if (en_y) begin
            read_out_y <= mem_y[widx(addr_y)];
            for (int b = 0; b < 4; b++) if (we_y[b]) mem_y[widx(addr_y)][8*b +: 8] <= write_in_y[8*b +: 8];
        end
        if (en_z) begin
            read_out_z <= mem_z[widx(addr_z)];
            for (int b = 0; b < 4; b++) if (we_z[b]) mem_z[widx(addr_z)][8*b +: 8] <= write_in_z[8*b +: 8];
        end
        if (acc_cmd != acc_done) begin
            for (int i = 0; i < MAXP; i++) begin
                if (acc_zmask[i]) begin
                    mem_x[1 + i/2][16*(i%2) +: 16] <= '0;
                    mem_y[1 + i/2][16*(i%2) +: 16] <= '0;
                    mem_z[1 + i/2][16*(i%2) +: 16] <= '0;
                end
            end
            mem_y[0] <= '0;
            mem_z[0] <= 32'h0000_0FFF;
            acc_done <= acc_cmd;
        end
    end

    // Point list and expected output stream
    logic [15:0] px [0:15];
    logic [15:0] py [0:15];
    logic [15:0] pz [0:15];
    logic [15:0] ex_x [0:15];
    logic [15:0] ex_y [0:15];
    logic [15:0] ex_z [0:15];
    logic        ex_o [0:15];
    logic        ex_l [0:15];
    logic        log_o [0:15];
    int          exp_n = 0, exp_base = 0, emit_cnt = 0, cmp_idx = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    bit          ovf_exp = 1'b0;

    // Output comparator
    initial begin
        forever begin
            @(negedge clock);
            if (out_valid) begin
                cmp_idx = emit_cnt - exp_base;
                if (cmp_idx >= exp_n) begin
                    chk("extra_point", 1, 0);
                end else begin
                    chk($sformatf("pt%0d_x", cmp_idx), out_x, ex_x[cmp_idx]);
                    chk($sformatf("pt%0d_y", cmp_idx), out_y, ex_y[cmp_idx]);
                    chk($sformatf("pt%0d_z", cmp_idx), out_z, ex_z[cmp_idx]);
                    chk($sformatf("pt%0d_outlier", cmp_idx), out_outlier, ex_o[cmp_idx]);
                    chk($sformatf("pt%0d_last", cmp_idx), out_last, ex_l[cmp_idx]);
                    if (out_ready) log_o[cmp_idx] = out_outlier;
                end
                if (prev_stall) chk("stall_addr_stable", addr_x, prev_addr);
                if (out_ready) emit_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_addr  = addr_x;
        end
    end

    task automatic send_points(input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            bit acc;
            gap = $urandom_range(0, 2);
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clock); #1; end
            in_valid = 1'b1;
            in_x = px[i];  in_y = py[i];  in_z = pz[i];
            in_last = (i == n - 1);
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clock);
                acc = in_ready;
                @(posedge clock); #1;
            end
            chk($sformatf("in%0d_accepted", i), acc, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_cloud(input int n, input int pin, output bit ok);
        int          stored, w, hl;
        logic [31:0] guard;
        bit          seen;
        stored = (n > MAXP) ? MAXP : n;
        guard  = mem_x[1 + MAXP/2];
        if (n > MAXP) ovf_exp = 1'b1;
        send_points(n);
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(posedge clock); #1;
            seen = (mem_y[0] != '0);
        end
        chk("start_request_seen", seen, 1);
        ok = seen;
        if (!seen) return;
        chk("hdr_count", mem_x[0], stored);
        chk("hdr_start", mem_y[0], 1);
        chk("hdr_done_clear", mem_z[0], 0);
        for (int i = 0; i < stored; i++) begin
            w  = 1 + i/2;
            hl = 16 * (i % 2);
            chk($sformatf("mem_x_pt%0d", i), (mem_x[w] >> hl) & 32'hFFFF, px[i]);
            chk($sformatf("mem_y_pt%0d", i), (mem_y[w] >> hl) & 32'hFFFF, py[i]);
            chk($sformatf("mem_z_pt%0d", i), (mem_z[w] >> hl) & 32'hFFFF, pz[i]);
        end
        if (stored % 2 == 1) begin
            w = 1 + stored/2;
            chk("flush_upper_x", mem_x[w] >> 16, 0);
            chk("flush_upper_y", mem_y[w] >> 16, 0);
            chk("flush_upper_z", mem_z[w] >> 16, 0);
        end
        if (n > MAXP) chk("guard_word_untouched", mem_x[1 + MAXP/2], guard);
        chk("overflow_flag", overflow, ovf_exp);
        if (pin == 1) begin
            chk("pin_x_w1", mem_x[1], 32'h0002_0001);
            chk("pin_x_w2", mem_x[2], 32'h0004_0003);
            chk("pin_y_w1", mem_y[1], 32'h000C_000B);
            chk("pin_z_w2", mem_z[2], 32'h0018_0017);
            chk("pin_x_w0", mem_x[0], 4);
        end else if (pin == 2) begin
            chk("pin_flush_x_w2", mem_x[2], 32'h0000_0003);
            chk("pin_x_w0_3", mem_x[0], 3);
        end else if (pin == 3) begin
            chk("pin_ovf_x_w0", mem_x[0], 8);
        end
    endtask

    task automatic unload_cloud(input int stored, input logic [15:0] zmask, input int stall_len, input int pin);
        int sc;
        bit done;
        for (int i = 0; i < stored; i++) begin
            ex_x[i] = zmask[i] ? 16'h0 : px[i];
            ex_y[i] = zmask[i] ? 16'h0 : py[i];
            ex_z[i] = zmask[i] ? 16'h0 : pz[i];
            ex_o[i] = (ex_x[i] == 0) && (ex_y[i] == 0) && (ex_z[i] == 0);
            ex_l[i] = (i == stored - 1);
            log_o[i] = 1'bx;
        end
        exp_base = emit_cnt;
        exp_n    = stored;
        repeat (10) begin @(posedge clock); #1; end
        acc_zmask = zmask;
        acc_cmd++;
        for (int t = 0; t < 5 && acc_done != acc_cmd; t++) begin @(posedge clock); #1; end
        sc = 0;
        done = 1'b0;
        for (int t = 0; t < 800 && !done; t++) begin
            @(posedge clock); #1;
            if (!busy) begin
                done = 1'b1;
            end else if (out_valid) begin
                if (stall_len >= 0) begin
                    out_ready = (sc >= stall_len);
                    sc = out_ready ? 0 : sc + 1;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end else begin
                out_ready = $urandom_range(0, 1) == 1;
            end
        end
        out_ready = 1'b0;
        chk("unload_finished", done, 1);
        chk("points_emitted", emit_cnt - exp_base, stored);
        chk("finish_done_clear", mem_z[0], 0);
        if (pin == 1) begin
            chk("pin_pt0_outlier", log_o[0], 0);
            chk("pin_pt1_outlier", log_o[1], 1);
            chk("pin_pt3_outlier", log_o[3], 0);
        end else if (pin == 2) begin
            chk("pin_three_emitted", emit_cnt - exp_base, 3);
        end
        $display("cloud: %0d points, zero mask 0x%0h, stall %0d, emitted %0d", stored, zmask, stall_len, emit_cnt - exp_base);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n;
        @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_en_x", en_x, 0);
        chk("rst_we", {we_x, we_y, we_z}, 0);
        chk("rst_addr_x", addr_x, 0);
        chk("rst_write_in_x", write_in_x, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        @(posedge clock); #1;

        for (int i = 0; i < 4; i++) begin
            px[i] = 16'(i + 1);  py[i] = 16'(i + 11);  pz[i] = 16'(i + 21);
        end
        load_cloud(4, 1, ok);
        if (ok) unload_cloud(4, 16'h0002, 5, 1);

        for (int i = 0; i < 3; i++) begin
            px[i] = 16'(i + 1);  py[i] = 16'(i + 11);  pz[i] = 16'(i + 21);
        end
        load_cloud(3, 2, ok);
        if (ok) unload_cloud(3, 16'h0000, -1, 2);

        for (int c = 0; c < 6; c++) begin
            n = $urandom_range(1, MAXP);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    px[i] = '0;  py[i] = '0;  pz[i] = '0;
                end else begin
                    px[i] = 16'($urandom);  py[i] = 16'($urandom);  pz[i] = 16'($urandom);
                end
            end
            load_cloud(n, 0, ok);
            if (ok) unload_cloud(n, 16'($urandom) & 16'((1 << n) - 1),
                                 ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 3)), 0);
        end

        for (int i = 0; i < 10; i++) begin
            px[i] = 16'(100 + i);  py[i] = 16'(200 + i);  pz[i] = 16'(300 + i);
        end
        load_cloud(10, 3, ok);
        if (ok) unload_cloud(MAXP, 16'h0000, 0, 0);

        for (int i = 0; i < 3; i++) begin
            px[i] = 16'($urandom);  py[i] = 16'($urandom);  pz[i] = 16'($urandom);
        end
        load_cloud(3, 0, ok);
        if (ok) begin
            @(posedge clock); #1;
            reset = 1'b1;
            @(negedge clock);
            chk("abort_we", {we_x, we_y, we_z}, 0);
            chk("abort_en_x", en_x, 0);
            chk("abort_busy", busy, 0);
            chk("abort_out_valid", out_valid, 0);
            @(posedge clock); #1;
            reset = 1'b0;
            ovf_exp = 1'b0;
            @(negedge clock);
            chk("after_abort_busy", busy, 0);
            chk("after_abort_overflow", overflow, 0);
            chk("after_abort_in_ready", in_ready, 1);
            chk("after_abort_en_x", en_x, 0);
            chk("after_abort_y_w0", mem_y[0], 1);
            chk("after_abort_z_w0", mem_z[0], 0);
            $display("abort: reset in poll loop, busy=%0d overflow=%0d", busy, overflow);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
